// File: rtl/mon_prod_param.sv
// Bit-serial Montgomery product engine: P = A*B*2^-n mod M, n = num_bits (1..BIT_LEN).
// The engine scans one multiplicand bit per clock, then spends one clock on the optional final
// subtraction. It has an async reset, a busy/done/err handshake and request validation.
module mon_prod_param #(
   parameter int BIT_LEN = 64,
   parameter int CNT_W   = $clog2(BIT_LEN) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [BIT_LEN-1:0] A,
   input  logic [BIT_LEN-1:0] B,
   input  logic [BIT_LEN-1:0] M,
   input  logic [CNT_W-1:0]   num_bits,
   input  logic               reduce,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [BIT_LEN:0]   P
);

   localparam int                 ACC_W = BIT_LEN + 2;
   localparam int                 P_W   = BIT_LEN + 1;
   localparam logic [CNT_W-1:0]   MAX_N = CNT_W'(BIT_LEN);
   localparam logic [CNT_W-1:0]   ONE_N = CNT_W'(1);
   localparam logic [BIT_LEN-1:0] ONE_A = BIT_LEN'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FIN
   } state_t;

   state_t             r_state;
   state_t             w_next_state;

   // Operands captured at the accepting edge; the ports may change freely afterwards.
   logic [BIT_LEN-1:0] r_a;
   logic [BIT_LEN-1:0] r_b;
   logic [BIT_LEN-1:0] r_m;
   logic [CNT_W-1:0]   r_n;
   logic               r_reduce;

   // Accumulator holds values below 2M between steps; the extra two bits absorb the
   // intermediate sum acc + B + M, which stays below 4M.
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic [P_W-1:0]     r_p;

   logic               w_capture;
   logic               w_req_valid;
   logic               w_last;
   logic               w_a_bit;
   logic [ACC_W-1:0]   w_sum;
   logic [ACC_W-1:0]   w_sum_m;
   logic [ACC_W-1:0]   w_step_acc;
   logic               w_ge_m;
   logic [ACC_W-1:0]   w_red_acc;
   logic [P_W-1:0]     w_fin;

   logic [ACC_W-1:0]   w_acc_next;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_busy_next;
   logic               w_done_next;
   logic               w_err_next;
   logic [P_W-1:0]     w_p_next;

   // Request qualification: a zero or oversized length, or an even modulus, is rejected.
   assign w_capture   = (r_state == S_IDLE) && start;
   assign w_req_valid = (num_bits != '0) && (num_bits <= MAX_N) && M[0];

   // One Montgomery step: add B if the scanned bit of A is set, make the sum even by
   // adding M, then halve. Halving an even number is an exact division by two mod M.
   assign w_last     = (r_cnt == r_n - ONE_N);
   assign w_a_bit    = |(r_a & (ONE_A << r_cnt));
   assign w_sum      = r_acc + (w_a_bit ? {2'b00, r_b} : '0);
   assign w_sum_m    = w_sum[0] ? (w_sum + {2'b00, r_m}) : w_sum;
   assign w_step_acc = w_sum_m >> 1;

   // Final conditional subtraction; the result never needs more than BIT_LEN+1 bits.
   assign w_ge_m    = (r_acc >= {2'b00, r_m});
   assign w_red_acc = (r_reduce && w_ge_m) ? (r_acc - {2'b00, r_m}) : r_acc;
   assign w_fin     = P_W'(w_red_acc);

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: IDLE -> ITER (valid request) -> FIN after n steps -> IDLE.
   always_comb begin
      // NOTE: a default assignment on entry keeps every path assigned, so no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (start && w_req_valid) w_next_state = S_ITER;
         S_ITER: if (w_last) w_next_state = S_FIN;
         S_FIN:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output and datapath next values for each state.
   always_comb begin
      w_acc_next  = r_acc;
      w_cnt_next  = r_cnt;
      w_busy_next = r_busy;
      w_done_next = 1'b0;
      w_err_next  = 1'b0;
      w_p_next    = r_p;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_req_valid) begin
                  w_busy_next = 1'b1;
                  w_acc_next  = '0;
                  w_cnt_next  = '0;
               end else begin
                  w_done_next = 1'b1;
                  w_err_next  = 1'b1;
                  w_p_next    = '0;
               end
            end
         end
         S_ITER: begin
            w_acc_next = w_step_acc;
            w_cnt_next = r_cnt + ONE_N;
         end
         S_FIN: begin
            w_p_next    = w_fin;
            w_busy_next = 1'b0;
            w_done_next = 1'b1;
         end
         default: begin
            w_busy_next = 1'b0;
         end
      endcase
   end

   // Control and result registers, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_p    <= '0;
      end else begin
         r_acc  <= w_acc_next;
         r_cnt  <= w_cnt_next;
         r_busy <= w_busy_next;
         r_done <= w_done_next;
         r_err  <= w_err_next;
         r_p    <= w_p_next;
      end
   end

   // Operand capture on any start seen in IDLE.
   // NOTE: these flops are always written before they are read, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_a      <= A;
         r_b      <= B;
         r_m      <= M;
         r_n      <= num_bits;
         r_reduce <= reduce;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;
   assign P    = r_p;

endmodule

// File: tb/tb_mon_prod_param.sv
// Self-checking bench for mon_prod_param: a transaction-level model predicts busy/done/err
// every cycle and the Montgomery result from modular arithmetic; directed cases pin exact values.
module tb_mon_prod_param;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] a_in = '0;
   logic [63:0] b_in = '0;
   logic [63:0] m_in = 64'd1;
   logic [6:0]  nb = 7'd1;
   logic        red = 1'b0;
   logic        busy;
   logic        done;
   logic        err;
   logic [64:0] p;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int cap     = 0;
   bit chk_en  = 1'b0;

   // Model state.
   int          m_left = 0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   bit          m_err  = 1'b0;
   bit          m_red  = 1'b0;
   logic [63:0] m_r    = '0;
   logic [63:0] m_m    = 64'd1;

   mon_prod_param dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .A        (a_in),
      .B        (b_in),
      .M        (m_in),
      .num_bits (nb),
      .reduce   (red),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .P        (p)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // A*B*2^-n mod M by plain modular arithmetic: reduce the product, then halve n times mod M.
   function automatic logic [63:0] mont_ref(input logic [63:0] a_v, input logic [63:0] b_v,
                                            input logic [63:0] m_v, input int n_v);
      logic [127:0] x;
      logic [127:0] mm;
      mm = {64'd0, m_v};
      x  = ({64'd0, a_v} * {64'd0, b_v}) % mm;
      for (int k = 0; k < n_v; k++) x = x[0] ? ((x + mm) >> 1) : (x >> 1);
      return x[63:0];
   endfunction

   // Transaction model: a valid request keeps busy for n+1 cycles then pulses done;
   // a rejected request pulses done/err at once; starts while busy are dropped.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_err  = 1'b0;
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (start) begin
            if (nb == 7'd0 || nb > 7'd64 || !m_in[0]) begin
               m_done = 1'b1;
               m_err  = 1'b1;
            end else begin
               m_left = int'(nb) + 1;
               m_busy = 1'b1;
               m_r    = mont_ref(a_in, b_in, m_in, int'(nb));
               m_m    = m_in;
               m_red  = red;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, m_busy);
         check("done", done, m_done);
         check("err", err, m_err);
         if (m_done && m_err) begin
            check("p_on_err", p, 0);
         end else if (m_done && m_red) begin
            check("p_reduced", p, m_r);
         end else if (m_done) begin
            check("p_mod_m", {63'd0, p} % {64'd0, m_m}, m_r);
            check("p_below_2m", {63'd0, p} < ({64'd0, m_m} << 1), 1);
         end
      end
   end

   // Drive a request at the current negedge; returns at the negedge after the capture edge.
   task automatic launch(input logic [63:0] a_v, input logic [63:0] b_v, input logic [63:0] m_v,
                         input logic [6:0] n_v, input logic r_v);
      a_in  = a_v;
      b_in  = b_v;
      m_in  = m_v;
      nb    = n_v;
      red   = r_v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cap   = cyc;
   endtask

   // Wait (bounded) for done; reports cycles since capture and busy cycles seen.
   task automatic wait_done(output int lat, output int busy_cyc);
      busy_cyc = 0;
      lat      = -1;
      for (int k = 0; k < 200; k++) begin
         if (done) begin
            lat = cyc - cap;
            return;
         end
         if (busy) busy_cyc++;
         @(negedge clk);
      end
      check("done_timeout", 0, 1);
   endtask

   // Random operand set honouring the contract, occasionally an invalid request.
   task automatic rand_ops(input bit allow_bad);
      logic [63:0] mask;
      logic [63:0] r64;
      int          n_v;
      n_v  = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(1, 64);
      mask = (n_v == 64) ? '1 : ((64'd1 << n_v) - 64'd1);
      r64  = {$urandom, $urandom};
      m_in = (r64 & mask) | 64'd1;
      a_in = {$urandom, $urandom} % m_in;
      b_in = {$urandom, $urandom} % m_in;
      nb   = 7'(n_v);
      red  = 1'($urandom_range(0, 1));
      if (allow_bad && $urandom_range(0, 11) == 0) begin
         case ($urandom_range(0, 2))
            0:       nb = 7'd0;
            1:       nb = 7'($urandom_range(65, 127));
            default: m_in = m_in & ~64'd1;
         endcase
      end
   endtask

   initial begin
      int lat;
      int bc;

      // Reset state.
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_p", p, 0);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Case 1: reference product.
      launch(64'd216, 64'd123, 64'd311, 7'd9, 1'b1);
      wait_done(lat, bc);
      check("c1_latency", lat, 10);
      check("c1_p", p, 290);
      check("c1_err", err, 0);
      @(negedge clk);

      // Case 2: no final subtraction.
      launch(64'd216, 64'd123, 64'd311, 7'd9, 1'b0);
      wait_done(lat, bc);
      check("c2_mod", {63'd0, p} % 128'd311, 290);
      check("c2_below_622", p < 65'd622, 1);
      @(negedge clk);

      // Case 3: full width, M = 2^64-1, A = B = M-1 gives 1.
      launch(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b1);
      wait_done(lat, bc);
      check("c3_latency", lat, 65);
      check("c3_busy_cycles", bc, 65);
      check("c3_p", p, 1);
      @(negedge clk);

      // Case 4: rejected requests.
      launch(64'd216, 64'd123, 64'd310, 7'd9, 1'b1);
      check("c4_even_done", done, 1);
      check("c4_even_err", err, 1);
      check("c4_even_p", p, 0);
      check("c4_even_busy", busy, 0);
      @(negedge clk);
      check("c4_pulse_width", done, 0);
      launch(64'd216, 64'd123, 64'd311, 7'd0, 1'b1);
      check("c4_n0_err", err, 1);
      @(negedge clk);
      launch(64'd216, 64'd123, 64'd311, 7'd65, 1'b1);
      check("c4_n65_err", err, 1);
      check("c4_n65_busy", busy, 0);
      @(negedge clk);

      // Case 5: start while busy is ignored; start in the done cycle is accepted.
      launch(64'd216, 64'd123, 64'd311, 7'd9, 1'b1);
      repeat (3) @(negedge clk);
      a_in  = 64'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc);
      check("c5_p_ignored", p, 290);
      launch(64'd1, 64'd1, 64'd3, 7'd2, 1'b1);
      wait_done(lat, bc);
      check("c5_b2b_latency", lat, 3);
      check("c5_b2b_p", p, 1);
      @(negedge clk);

      // Case 6: reset mid-operation, then rerun.
      launch(64'd216, 64'd123, 64'd311, 7'd9, 1'b1);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("c6_busy", busy, 0);
      check("c6_done", done, 0);
      check("c6_p", p, 0);
      repeat (12) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      launch(64'd216, 64'd123, 64'd311, 7'd9, 1'b1);
      wait_done(lat, bc);
      check("c6_rerun_p", p, 290);
      @(negedge clk);

      // Random phase: free-running stimulus, inputs change every cycle, one reset mid-way.
      for (int c = 0; c < 3000; c++) begin
         rand_ops(1'b1);
         start = ($urandom_range(0, 3) == 0);
         if (c == 1500) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      start = 1'b0;
      repeat (80) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
